md6_joystick_scanner: RTL

Host-side scan controller for a Mega Drive 6-button joystick port. Drives the port select line (pin 7) through a fixed 8-phase sequence, samples the six active-low data lines in each phase, and detects pad presence and 3- vs 6-button type. At the end of each scan it publishes an atomic, active-high 12-bit button word whose bit layout matches the team's virtual-joystick vector. It sits between the joystick pads (or the virtual joystick emulator in simulation) and the joystick mux/port-register logic.

---
 rtl/md6_joystick_scanner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/md6_joystick_scanner.sv
// md6_joystick_scanner
//   Host-side scan controller for a Mega Drive 6-button pad. It walks the
//   select line through an idle gap followed by eight select phases, samples
//   the pad data at the end of each phase, and publishes one atomic button word
//   per scan. The word layout is {MODE,X,Z,Y,START,A,C,B,U,D,L,R}, active-high.
//
// Ports
//   clk, reset    : system clock, asynchronous active-high reset
//   scan_en       : level, allows a new scan to start after the gap
//   data_in[5:0]  : pad data pins, active-low, asynchronous to clk
//   select_out    : pad select (pin 7), registered, high while idle
//   buttons[11:0] : last published button word
//   is_6button    : last scan saw a 6-button pad
//   connected     : last scan saw a pad
//   valid         : one-cycle pulse when the three outputs above update
//   busy          : high during the eight select phases
module md6_joystick_scanner #(
    parameter int PHASE_CYCLES = 56,
    parameter int GAP_CYCLES   = 56000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [5:0]  data_in,
    output logic        select_out,
    output logic [11:0] buttons,
    output logic        is_6button,
    output logic        connected,
    output logic        valid,
    output logic        busy
);

    localparam int PH_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [3:0] {
        S_GAP, S_PH0, S_PH1, S_PH2, S_PH3, S_PH4, S_PH5, S_PH6, S_PH7
    } state_t;

    state_t state_q, state_d;

    logic [5:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [5:0]       d;
    logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             ph_last, gap_expired, publish, scan_start;

    logic [11:0]      sh_btn_q, sh_btn_d;
    logic             sh_conn_q, sh_conn_d;
    logic             sh_six_q, sh_six_d;

    logic [11:0]      buttons_q, buttons_d;
    logic             is6_q, is6_d, conn_q, conn_d, valid_q, valid_d;
    logic             select_q, select_d, busy_q, busy_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_GAP;
            select_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            busy_q   <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_GAP:   if (gap_expired && scan_en) state_d = S_PH0;
            S_PH7:   if (ph_last) state_d = S_GAP;
            default: if (ph_last) state_d = state_t'(state_q + 4'd1);
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so the registered select
    // and busy line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        select_d = 1'b1;
        busy_d   = (state_d != S_GAP);
        unique case (state_d)
            S_PH1, S_PH3, S_PH5, S_PH7: select_d = 1'b0;
            default:                    select_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: synchronizer, phase/gap counters, shadow capture, publish
    // ------------------------------------------------------------------
    assign d           = ~sync2_q;
    assign ph_last     = (state_q != S_GAP) && (ph_cnt_q == PH_LAST);
    // Expired one count early so the gap lasts exactly GAP_CYCLES cycles.
    assign gap_expired = (gap_cnt_q <= GAP_W'(1));
    assign publish     = (state_q == S_PH7) && ph_last;
    assign scan_start  = (state_q == S_GAP) && (state_d == S_PH0);

    always_comb begin
        sync1_d   = data_in;
        sync2_d   = sync1_q;

        ph_cnt_d  = (state_q == S_GAP || ph_last) ? '0 : ph_cnt_q + PH_W'(1);

        gap_cnt_d = gap_cnt_q;
        if (publish)
            gap_cnt_d = GAP_LOAD;
        else if (state_q == S_GAP && gap_cnt_q != '0)
            gap_cnt_d = gap_cnt_q - GAP_W'(1);

        sh_btn_d  = sh_btn_q;
        sh_conn_d = sh_conn_q;
        sh_six_d  = sh_six_q;
        if (scan_start) begin
            sh_btn_d  = '0;
            sh_conn_d = 1'b0;
            sh_six_d  = 1'b0;
        end else if (ph_last) begin
            unique case (state_q)
                S_PH0: sh_btn_d[5:0] = {d[5], d[4], d[0], d[1], d[2], d[3]};
                S_PH1: begin
                    sh_btn_d[7:6] = d[5:4];
                    // A pad grounds pins 3/4 while select is low.
                    sh_conn_d     = (d[3:2] == 2'b11);
                end
                // 6-button pads ground all four direction pins here.
                S_PH5: sh_six_d = (d[1:0] == 2'b11);
                S_PH6: if (sh_six_q) sh_btn_d[11:8] = {d[3], d[2], d[0], d[1]};
                default: ;
            endcase
        end

        buttons_d = buttons_q;
        is6_d     = is6_q;
        conn_d    = conn_q;
        valid_d   = publish;
        if (publish) begin
            conn_d    = sh_conn_q;
            is6_d     = sh_conn_q & sh_six_q;
            if (!sh_conn_q)
                buttons_d = '0;
            else if (sh_six_q)
                buttons_d = sh_btn_q;
            else
                buttons_d = {4'b0000, sh_btn_q[7:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            ph_cnt_q  <= '0;
            gap_cnt_q <= GAP_LOAD;
            sh_btn_q  <= '0;
            sh_conn_q <= 1'b0;
            sh_six_q  <= 1'b0;
            buttons_q <= '0;
            is6_q     <= 1'b0;
            conn_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            ph_cnt_q  <= ph_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sh_btn_q  <= sh_btn_d;
            sh_conn_q <= sh_conn_d;
            sh_six_q  <= sh_six_d;
            buttons_q <= buttons_d;
            is6_q     <= is6_d;
            conn_q    <= conn_d;
            valid_q   <= valid_d;
        end
    end

    assign select_out = select_q;
    assign busy       = busy_q;
    assign buttons    = buttons_q;
    assign is_6button = is6_q;
    assign connected  = conn_q;
    assign valid      = valid_q;

endmodule
